attention_score_stream: RTL and testbench
=========================================

// Module: attention_score_stream
// PURPOSE
//  Next-generation attention-score engine: A = (Q*K^T) * 1/sqrt(E), per head, Q1.15 in/out.
//  Computes one score at a time on a LANES-wide MAC and streams it out on a valid/ready port.
//  The full MxKxN array and the full-matrix output register are not needed.
//  Sits between the QKV projection and softmax; softmax consumes scores in out_idx order.
// PARAMETERS
//  DATA_WIDTH  16  element width, signed Q1.15 (only 16 supported)
//  L           16  sequence length (tokens)
//  N           1   number of heads
//  E           16  per-head embedding dim; must be a multiple of LANES
//  LANES       4   parallel multipliers per cycle, 1..E
//  ACC_WIDTH   40  signed accumulator width; elaboration error if < 2*DATA_WIDTH+$clog2(E)+1
// PORTS
//  clk        in   1                clock
//  rst        in   1                synchronous reset, active-high
//  start      in   1                begin a run (accepted only in IDLE)
//  busy       out  1                high from the cycle after an accepted start until done
//  done       out  1                one-cycle pulse after the last output handshake
//  Q_in       in   DW x L*N*E       Q, index i*N*E+h*E+e; must be held stable while busy
//  K_in       in   DW x L*N*E       K, same layout; must be held stable while busy
//  out_valid  out  1                out_data/out_idx valid
//  out_ready  in   1                consumer accepts when out_valid&&out_ready
//  out_data   out  DW               scaled, saturated score, Q1.15
//  out_idx    out  $clog2(L*N*L)    flat index i*N*L+h*L+j (query i, head h, key j)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, out_valid=0; out_data, out_idx, counters, acc=0.
//  Emission order: i outer, h middle, j inner, so out_idx steps 0,1,..,L*N*L-1.
//  FSM states and transitions:
//   IDLE: start -> ACCUM, clear acc and counters (i,h,j,e)=0.
//   ACCUM: acc += sum over LANES of Q[i,h,e+l]*K[j,h,e+l]; e += LANES.
//     Leaves for SCALE after E/LANES cycles.
//   SCALE: p = acc * INV_SQRT_E (17-bit unsigned Q1.16 const).
//     out_data = sat16(p >>> 31), arithmetic shift, floor, clamp to [0x8000,0x7FFF].
//     Sets out_valid=1 -> EMIT.
//   EMIT: hold out_valid/out_data/out_idx stable until out_ready.
//     On handshake: if last idx -> DONE, else advance j/h/i, clear acc, -> ACCUM.
//   DONE: done=1 for one cycle, busy=0 -> IDLE.
//  Latency: E/LANES+2 cycles per score with out_ready=1; first out_valid E/LANES+1 cycles after start.
//  INV_SQRT_E = round(2^16/sqrt(E)), computed at elaboration by a package function.
//  Boundary conditions:
//   start while busy: ignored.
//   out_ready high when out_valid=0: no effect.
//   out_ready low: pipeline stalls, nothing dropped or duplicated.
//   rst mid-run: immediate return to reset values; no done pulse.
//   start in the DONE cycle: ignored.
// CONFIGURATION
//  ATTN_CAUSAL_MASK_EN defined:
//   Scores with j>i spend exactly one ACCUM cycle with no MAC, then go straight to EMIT.
//   They emit out_data=0x8000 (most negative, so softmax drives them to ~0).
//   The SCALE state is skipped for masked scores.
//  ATTN_CAUSAL_MASK_EN undefined: every score is computed and no masking logic exists.
// STRUCTURE
//  attn_pkg holds:
//   - attn_state_t (IDLE, ACCUM, SCALE, EMIT, DONE)
//   - function inv_sqrt_q16(E)
//   - function sat_q15(logic signed [ACC_WIDTH+16:0])
//   - localparam Q15_MIN=16'h8000 and Q15_MAX=16'h7FFF
//  One sub-module, attn_dot_lanes: LANES signed DWxDW multipliers plus an adder tree.
//   Purely combinational; the accumulator register stays in the top.
// TESTING (L=4, N=2, E=16, LANES=4, INV_SQRT_E=0x4000)
//  1 Q=K=0x2000 everywhere, out_ready=1:
//    32 outputs, all 0x2000, idx 0..31 in order, 6 cycles apart, then one done pulse.
//  2 Q=0x2000, K=0xE000: all outputs 0xE000.
//    Q=K=0x4000: all outputs saturate to 0x7FFF.
//  3 out_ready low for 5 cycles while idx=3 is valid:
//    out_valid stays high, data/idx stay stable, the next idx is 4 and none is skipped.
//  4 rst pulsed while idx=10 is pending:
//    next cycle busy=0 and out_valid=0; a fresh start restarts at idx 0.
//  5 start pulsed while busy: no effect on order or count.
//  6 ATTN_CAUSAL_MASK_EN with Q=K=0x2000:
//    idx with j>i (e.g. idx 1 = i0,h0,j1) emits 0x8000; idx with j<=i emits 0x2000.

Source files
------------

// File: rtl/attn_pkg.sv
// Shared types, constants and helper functions for the attention-score stream.
package attn_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    SCALE = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } attn_state_t;

  localparam logic [15:0] Q15_MIN = 16'h8000;
  localparam logic [15:0] Q15_MAX = 16'h7FFF;

  // Width of the scaled product handed to sat_q15; the accumulator is
  // sign-extended into this so the helper stays independent of ACC_WIDTH.
  localparam int SAT_IN_W = 64;

  // round(2^16 / sqrt(e_dim)) as an unsigned Q1.16 value.
  // Uses round(sqrt(v)) = floor((floor(sqrt(4v)) + 1) / 2) with v = 2^32/e_dim.
  function automatic logic [16:0] inv_sqrt_q16(input int unsigned e_dim);
    longint unsigned v;
    longint unsigned t;
    longint unsigned trial;
    v = 64'h0000_0004_0000_0000 / longint'(e_dim);
    t = 64'd0;
    for (int b = 17; b >= 0; b--) begin
      trial = t | (64'd1 << b);
      if ((trial * trial) <= v) begin
        t = trial;
      end else begin
        t = t;
      end
    end
    return 17'((t + 64'd1) >> 1);
  endfunction

  // Arithmetic shift by 31 (floor) followed by a clamp to the Q1.15 range.
  function automatic logic [15:0] sat_q15(input logic signed [SAT_IN_W-1:0] p);
    logic signed [SAT_IN_W-1:0] s;
    logic [SAT_IN_W-16:0] hi;
    logic [15:0] r;
    s  = p >>> 32'd31;
    hi = s[SAT_IN_W-1:15];
    if ((&hi) || (~|hi)) begin
      r = s[15:0];
    end else if (s[SAT_IN_W-1]) begin
      r = Q15_MIN;
    end else begin
      r = Q15_MAX;
    end
    return r;
  endfunction

endpackage

// File: rtl/attention_score_stream_if.sv
// Score output stream: valid/ready handshake carrying one Q1.15 score and its flat index.
interface attention_score_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 8
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0]  out_idx;

  modport master (output out_valid, output out_data, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/attn_dot_lanes.sv
// LANES-wide signed dot product: one DWxDW multiplier per lane and a sum of
// the lane products. Purely combinational; accumulation happens in the caller.
module attn_dot_lanes #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int DOT_W      = 2*DATA_WIDTH + 3
) (
  input  logic [LANES-1:0][DATA_WIDTH-1:0] a_lanes,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] b_lanes,
  output logic signed [DOT_W-1:0]          dot_sum
);

  logic signed [2*DATA_WIDTH-1:0] prod_s [LANES];

  // Per-lane full-precision signed products
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod_s[l] = (2*DATA_WIDTH)'($signed(a_lanes[l])) * (2*DATA_WIDTH)'($signed(b_lanes[l]));
    end
  end

  // Sign-extended reduction of the lane products
  always_comb begin
    dot_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      dot_sum = dot_sum + DOT_W'(prod_s[l]);
    end
  end

endmodule

// File: rtl/attention_score_stream.sv
// Attention-score engine: streams A[i,h,j] = (Q[i,h,:] . K[j,h,:]) / sqrt(E)
// one score at a time in out_idx order (i outer, h middle, j inner).
// Optional build macro ATTN_CAUSAL_MASK_EN: scores with j > i skip the MAC
// and are emitted as the most negative Q1.15 value after a single cycle.
module attention_score_stream
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 16,
  parameter int N          = 1,
  parameter int E          = 16,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  input  logic [DATA_WIDTH*L*N*E-1:0]    Q_in,
  input  logic [DATA_WIDTH*L*N*E-1:0]    K_in,
  attention_score_stream_if.master       out_if
);

  localparam int TOTAL = L*N*L;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int I_W   = (L > 1) ? $clog2(L) : 1;
  localparam int H_W   = (N > 1) ? $clog2(N) : 1;
  localparam int E_W   = (E > 1) ? $clog2(E) : 1;
  localparam int DOT_W = 2*DATA_WIDTH + $clog2(LANES) + 1;
  localparam logic signed [17:0] INV_S = signed'({1'b0, inv_sqrt_q16(32'(E))});

  if (DATA_WIDTH != 16) begin : g_dw_chk
    $error("attention_score_stream: only DATA_WIDTH=16 is supported");
  end
  if (ACC_WIDTH < 2*DATA_WIDTH + $clog2(E) + 1) begin : g_acc_chk
    $error("attention_score_stream: ACC_WIDTH too small for E");
  end
  if (ACC_WIDTH + 18 > SAT_IN_W) begin : g_sat_chk
    $error("attention_score_stream: ACC_WIDTH too large for the scaling path");
  end
  if ((LANES < 1) || (LANES > E) || ((E % LANES) != 0)) begin : g_lane_chk
    $error("attention_score_stream: E must be a multiple of LANES, 1 <= LANES <= E");
  end

  attn_state_t                   state_r;
  logic [I_W-1:0]                i_r;
  logic [H_W-1:0]                h_r;
  logic [I_W-1:0]                j_r;
  logic [E_W-1:0]                e_r;
  logic [IDX_W-1:0]              idx_r;
  logic signed [ACC_WIDTH-1:0]   acc_r;
  logic                          busy_r;
  logic                          done_r;
  logic                          out_valid_r;
  logic [DATA_WIDTH-1:0]         out_data_r;
  logic [IDX_W-1:0]              out_idx_r;

  logic [DATA_WIDTH-1:0]             q_arr_s [L][N][E];
  logic [DATA_WIDTH-1:0]             k_arr_s [L][N][E];
  logic [LANES-1:0][DATA_WIDTH-1:0]  q_lane_s;
  logic [LANES-1:0][DATA_WIDTH-1:0]  k_lane_s;
  logic signed [DOT_W-1:0]           dot_s;
  logic signed [SAT_IN_W-1:0]        prod_s;
  logic                              last_beat_s;
  logic                              last_idx_s;
  logic                              row_end_s;
  logic                              head_end_s;

`ifdef ATTN_CAUSAL_MASK_EN
  logic masked_s;
  assign masked_s = (j_r > i_r);
`endif

  // Unflatten the Q/K buses into [token][head][element] views
  always_comb begin
    for (int ti = 0; ti < L; ti++) begin
      for (int th = 0; th < N; th++) begin
        for (int te = 0; te < E; te++) begin
          q_arr_s[ti][th][te] = Q_in[((ti*N + th)*E + te)*DATA_WIDTH +: DATA_WIDTH];
          k_arr_s[ti][th][te] = K_in[((ti*N + th)*E + te)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Select the LANES elements of query i and key j for the current beat
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      q_lane_s[l] = q_arr_s[i_r][h_r][e_r + E_W'(l)];
      k_lane_s[l] = k_arr_s[j_r][h_r][e_r + E_W'(l)];
    end
  end

  attn_dot_lanes #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .DOT_W      (DOT_W)
  ) u_dot (
    .a_lanes (q_lane_s),
    .b_lanes (k_lane_s),
    .dot_sum (dot_s)
  );

  assign prod_s      = SAT_IN_W'(acc_r) * SAT_IN_W'(INV_S);
  assign last_beat_s = (e_r == E_W'(E - LANES));
  assign last_idx_s  = (idx_r == IDX_W'(TOTAL - 1));
  assign row_end_s   = (j_r == I_W'(L - 1));
  assign head_end_s  = (h_r == H_W'(N - 1));

  // Controller, counters, accumulator and registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      i_r         <= '0;
      h_r         <= '0;
      j_r         <= '0;
      e_r         <= '0;
      idx_r       <= '0;
      acc_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_idx_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= ACCUM;
            busy_r  <= 1'b1;
            acc_r   <= '0;
            i_r     <= '0;
            h_r     <= '0;
            j_r     <= '0;
            e_r     <= '0;
            idx_r   <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCUM: begin
`ifdef ATTN_CAUSAL_MASK_EN
          if (masked_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= Q15_MIN;
            out_idx_r   <= idx_r;
            state_r     <= EMIT;
          end else
`endif
          begin
            acc_r <= acc_r + ACC_WIDTH'(dot_s);
            if (last_beat_s) begin
              e_r     <= '0;
              state_r <= SCALE;
            end else begin
              e_r <= e_r + E_W'(LANES);
            end
          end
        end
        SCALE: begin
          out_valid_r <= 1'b1;
          out_data_r  <= sat_q15(prod_s);
          out_idx_r   <= idx_r;
          state_r     <= EMIT;
        end
        EMIT: begin
          if (out_if.out_ready) begin
            out_valid_r <= 1'b0;
            acc_r       <= '0;
            if (last_idx_s) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ACCUM;
              idx_r   <= idx_r + IDX_W'(1);
              if (row_end_s) begin
                j_r <= '0;
                if (head_end_s) begin
                  h_r <= '0;
                  i_r <= i_r + I_W'(1);
                end else begin
                  h_r <= h_r + H_W'(1);
                end
              end else begin
                j_r <= j_r + I_W'(1);
              end
            end
          end else begin
            state_r <= EMIT;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_r;
  assign done             = done_r;
  assign out_if.out_valid = out_valid_r;
  assign out_if.out_data  = out_data_r;
  assign out_if.out_idx   = out_idx_r;

endmodule

// File: tb/tb_attention_score_stream.sv
// Self-checking bench for attention_score_stream (L=4, N=2, E=16, LANES=4).
// Expected scores come from a direct dot-product model over the stimulus arrays.
module tb_attention_score_stream;

  localparam int DW        = 16;
  localparam int L         = 4;
  localparam int N         = 2;
  localparam int E         = 16;
  localparam int LANES     = 4;
  localparam int ACC_WIDTH = 40;
  localparam int TOTAL     = L*N*L;
  localparam int IDX_W     = $clog2(TOTAL);
  localparam int NEL       = L*N*E;
  localparam int BUDGET    = TOTAL*(E/LANES + 2)*4 + 50;

  localparam int M_READY = 0;
  localparam int M_STALL = 1;
  localparam int M_RAND  = 2;
  localparam int M_SPAM  = 3;
  localparam int M_ABORT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [DW*NEL-1:0] q_flat;
  logic [DW*NEL-1:0] k_flat;

  int n_asserts = 0;
  int n_fail    = 0;
  int inv_q16;

  attention_score_stream_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IDX_W)) sif ();

  attention_score_stream #(
    .DATA_WIDTH (DW),
    .L          (L),
    .N          (N),
    .E          (E),
    .LANES      (LANES),
    .ACC_WIDTH  (ACC_WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .Q_in   (q_flat),
    .K_in   (k_flat),
    .out_if (sif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_masked(input int idx);
`ifdef ATTN_CAUSAL_MASK_EN
    return (idx % L) > (idx / (N*L));
`else
    return (idx < 0);
`endif
  endfunction

  function automatic logic [15:0] model_score(input int idx);
    int qi, hh, kj;
    longint acc, p;
    logic [15:0] qe, ke;
    qi = idx / (N*L);
    hh = (idx / L) % N;
    kj = idx % L;
    if (is_masked(idx)) return 16'h8000;
    acc = 0;
    for (int e = 0; e < E; e++) begin
      qe = q_flat[((qi*N + hh)*E + e)*DW +: DW];
      ke = k_flat[((kj*N + hh)*E + e)*DW +: DW];
      acc += longint'($signed(qe)) * longint'($signed(ke));
    end
    p = (acc * longint'(inv_q16)) >>> 31;
    if (p > 32767) return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return p[15:0];
  endfunction

  function automatic logic [15:0] rnd16(input int kind);
    logic [15:0] v;
    v = 16'($urandom);
    if (kind == 1) v = {{3{v[12]}}, v[12:0]};
    return v;
  endfunction

  // kind 0: constants qv/kv; kind 1: small random; kind 2: full-range random
  task automatic fill(input int kind, input logic [15:0] qv, input logic [15:0] kv);
    for (int n = 0; n < NEL; n++) begin
      if (kind == 0) begin
        q_flat[n*DW +: DW] = qv;
        k_flat[n*DW +: DW] = kv;
      end else begin
        q_flat[n*DW +: DW] = rnd16(kind);
        k_flat[n*DW +: DW] = rnd16(kind);
      end
    end
  endtask

  task automatic run_stream(input int mode);
    int cyc, last_ref, exp_idx, stall_left;
    bit prev_valid, holding, fin, aborted;
    logic [DW-1:0] held_data;
    logic [IDX_W-1:0] held_idx;
    cyc = 0; last_ref = 0; exp_idx = 0; stall_left = 5;
    prev_valid = 1'b0; holding = 1'b0; fin = 1'b0; aborted = 1'b0;
    held_data = '0; held_idx = '0;
    sif.out_ready = (mode == M_READY || mode == M_STALL || mode == M_ABORT);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (!fin && cyc < BUDGET) begin
      if (holding)
        chk("stall_hold", {sif.out_valid, sif.out_data, sif.out_idx}, {1'b1, held_data, held_idx});
      if (sif.out_valid && !prev_valid) begin
        chk("latency", cyc - last_ref, is_masked(exp_idx) ? 1 : E/LANES + 1);
        chk("out_idx", sif.out_idx, exp_idx);
        chk("out_data", sif.out_data, model_score(exp_idx));
      end
      chk("busy_running", busy, 1);
      if (mode == M_ABORT && sif.out_valid && exp_idx == 10) begin
        rst = 1'b1;
        sif.out_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", sif.out_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_idx", sif.out_idx, 0);
        chk("abort_data", sif.out_data, 0);
        tick();
        chk("abort_no_done", done, 0);
        aborted = 1'b1;
        break;
      end
      case (mode)
        M_STALL: begin
          if (sif.out_valid && exp_idx == 3 && stall_left > 0) begin
            sif.out_ready = 1'b0;
            stall_left--;
          end else begin
            sif.out_ready = 1'b1;
          end
        end
        M_RAND, M_SPAM: sif.out_ready = ($urandom_range(0, 3) != 0);
        default: sif.out_ready = 1'b1;
      endcase
      if (sif.out_valid) begin
        if (sif.out_ready) begin
          exp_idx++;
          last_ref = cyc + 1;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          held_data = sif.out_data;
          held_idx = sif.out_idx;
        end
      end
      if (mode == M_SPAM) start = 1'($urandom_range(0, 1));
      prev_valid = sif.out_valid;
      tick();
      cyc++;
      if (done) begin
        fin = 1'b1;
        chk("score_count", exp_idx, TOTAL);
        chk("done_timing", cyc, last_ref);
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", sif.out_valid, 0);
      end
    end
    start = 1'b0;
    if (!aborted) begin
      chk("done_seen", fin, 1);
      if (mode == M_SPAM) start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_one_pulse", done, 0);
      chk("idle_after_done", busy, 0);
      tick();
      chk("start_in_done_ignored", busy, 0);
    end
  endtask

  initial begin
    inv_q16 = $rtoi(65536.0 / $sqrt(real'(E)) + 0.5);
    rst = 1'b1;
    start = 1'b0;
    sif.out_ready = 1'b0;
    q_flat = '0;
    k_flat = '0;
    tick();
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", sif.out_valid, 0);
    chk("reset_data", sif.out_data, 0);
    chk("reset_idx", sif.out_idx, 0);
    rst = 1'b0;
    sif.out_ready = 1'b1;
    tick();
    chk("idle_ready_no_effect", sif.out_valid, 0);

    fill(0, 16'h2000, 16'h2000);
    run_stream(M_READY);
    fill(0, 16'h2000, 16'hE000);
    run_stream(M_READY);
    fill(0, 16'h4000, 16'h4000);
    run_stream(M_READY);
    fill(0, 16'h2000, 16'h2000);
    run_stream(M_STALL);
    fill(1, 16'h0000, 16'h0000);
    run_stream(M_ABORT);
    run_stream(M_READY);
    fill(2, 16'h0000, 16'h0000);
    run_stream(M_SPAM);
    fill(1, 16'h0000, 16'h0000);
    run_stream(M_RAND);
    fill(2, 16'h0000, 16'h0000);
    run_stream(M_RAND);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
